// File: rtl/quant_stream_multich_pkg.sv
// Shared quantizer constants: JPEG base quantization tables, the default
// reciprocal tables derived from them, and the coefficient/reciprocal types.
package quant_stream_multich_pkg;

    localparam int FRAC_W_DEF  = 12;
    localparam int RECIP_W_DEF = 13;
    localparam int IN_W_DEF    = 11;
    localparam int OUT_W_DEF   = 11;
    localparam int BLK_BEATS   = 64;

    typedef logic signed [IN_W_DEF-1:0]  coef_t;
    typedef logic signed [OUT_W_DEF-1:0] qout_t;
    typedef logic        [RECIP_W_DEF-1:0] recip_t;
    typedef logic        [7:0]           qval_t;
    typedef logic [BLK_BEATS-1:0][RECIP_W_DEF-1:0] recip_tab_t;

    localparam qval_t Q_LUMA [BLK_BEATS] = '{
        8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
        8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
        8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
        8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
        8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
        8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
        8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
        8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
    };

    localparam qval_t Q_CHROMA [BLK_BEATS] = '{
        8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
    };

    // Reciprocal 2^FRAC_W_DEF / Q with integer division.
    function automatic recip_t recip_of(input qval_t q);
        return recip_t'((32'd1 << FRAC_W_DEF) / {24'd0, q});
    endfunction

    function automatic recip_tab_t build_recip(input bit chroma);
        recip_tab_t tab;
        tab = '0;
        for (int i = 0; i < BLK_BEATS; i++) begin
            tab[i] = chroma ? recip_of(Q_CHROMA[i]) : recip_of(Q_LUMA[i]);
        end
        return tab;
    endfunction

    localparam recip_tab_t RECIP_LUMA   = build_recip(1'b0);
    localparam recip_tab_t RECIP_CHROMA = build_recip(1'b1);

endpackage

// File: rtl/quant_stream_multich_round_sat.sv
// Combinational quantizer core: coefficient times reciprocal, round half up
// at the FRAC_W binary point, then saturate to the signed output range.
module quant_round_sat
    import quant_stream_multich_pkg::*;
#(
    parameter int IN_W    = 11,
    parameter int RECIP_W = 13,
    parameter int FRAC_W  = 12,
    parameter int OUT_W   = 11
) (
    input  logic [IN_W-1:0]    coef,
    input  logic [RECIP_W-1:0] recip,
    output logic [OUT_W-1:0]   result
);

    localparam int PW = IN_W + RECIP_W + 1;

    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [PW-1:0] coef_x;
    logic signed [PW-1:0] recip_x;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shr;
    logic signed [PW-1:0] rnd;

    // Multiply, round half up using the first discarded bit, clamp to range.
    always_comb begin
        coef_x  = {{(RECIP_W+1){coef[IN_W-1]}}, coef};
        recip_x = {{(IN_W+1){1'b0}}, recip};
        prod    = coef_x * recip_x;
        shr     = prod >>> FRAC_W;
        rnd     = shr + {{(PW-1){1'b0}}, prod[FRAC_W-1]};
        result  = rnd[OUT_W-1:0];
        if (rnd > SAT_MAX) begin
            result = SAT_MAX[OUT_W-1:0];
        end else if (rnd < SAT_MIN) begin
            result = SAT_MIN[OUT_W-1:0];
        end else begin
            result = rnd[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/quant_stream_multich.sv
// Shared streaming quantizer for all colour channels: one coefficient per
// beat, per-block channel tag, runtime-programmable reciprocal tables and a
// two-stage registered pipeline that freezes as a whole on backpressure.
module quant_stream_multich
    import quant_stream_multich_pkg::*;
#(
    parameter int IN_W    = 11,
    parameter int OUT_W   = 11,
    parameter int FRAC_W  = 12,
    parameter int RECIP_W = 13,
    parameter int N_CH    = 3,
    parameter int CH_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic [CH_W-1:0]    in_ch,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [5:0]         out_idx,
    output logic [CH_W-1:0]    out_ch,
    output logic               out_last,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [5:0]         cfg_idx,
    input  logic [RECIP_W-1:0] cfg_recip,
    output logic               cfg_err,
    output logic               busy
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
    localparam logic [CH_W-1:0] NUM_CH  = CH_W'(N_CH);

    // Power-on reciprocal for a table entry; channel 0 is luma, others chroma.
    function automatic logic [RECIP_W-1:0] default_recip(input bit chroma, input logic [5:0] idx);
        logic [31:0] q;
        q = chroma ? {24'd0, Q_CHROMA[idx]} : {24'd0, Q_LUMA[idx]};
        return RECIP_W'((32'd1 << FRAC_W) / q);
    endfunction

    logic [5:0]         count_r;
    logic [CH_W-1:0]    blk_ch_r;
    logic               s1_valid_r;
    logic [IN_W-1:0]    s1_data_r;
    logic [5:0]         s1_idx_r;
    logic [CH_W-1:0]    s1_ch_r;
    logic [RECIP_W-1:0] s1_recip_r;
    logic [RECIP_W-1:0] tbl_r [N_CH][BLK_BEATS];

    logic               stall_s;
    logic               accept_s;
    logic               busy_s;
    logic               cfg_ok_s;
    logic [CH_W-1:0]    in_ch_clamp_s;
    logic [CH_W-1:0]    beat_ch_s;
    logic [OUT_W-1:0]   rs_s;

    // Handshake, channel selection, busy and config-write qualification.
    always_comb begin
        stall_s  = out_valid && !out_ready;
        accept_s = in_valid && !stall_s;
        busy_s   = (count_r != 6'd0) || s1_valid_r || out_valid;
        in_ch_clamp_s = in_ch;
        if (in_ch >= NUM_CH) begin
            in_ch_clamp_s = LAST_CH;
        end else begin
            in_ch_clamp_s = in_ch;
        end
        beat_ch_s = blk_ch_r;
        if (count_r == 6'd0) begin
            beat_ch_s = in_ch_clamp_s;
        end else begin
            beat_ch_s = blk_ch_r;
        end
        cfg_ok_s = cfg_we && !busy_s && !accept_s && (cfg_ch < NUM_CH);
    end

    assign in_ready = !stall_s;
    assign busy     = busy_s;

    // Beat counter and channel latched at the first beat of each block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r  <= 6'd0;
            blk_ch_r <= '0;
        end else if (accept_s) begin
            count_r <= count_r + 6'd1;
            if (count_r == 6'd0) begin
                blk_ch_r <= in_ch_clamp_s;
            end
        end
    end

    // Stage 1: capture coefficient, position, channel and its reciprocal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
            s1_idx_r   <= 6'd0;
            s1_ch_r    <= '0;
            s1_recip_r <= '0;
        end else if (!stall_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_data_r  <= in_data;
                s1_idx_r   <= count_r;
                s1_ch_r    <= beat_ch_s;
                s1_recip_r <= tbl_r[beat_ch_s][count_r];
            end
        end
    end

    quant_round_sat #(
        .IN_W    (IN_W),
        .RECIP_W (RECIP_W),
        .FRAC_W  (FRAC_W),
        .OUT_W   (OUT_W)
    ) u_round_sat (
        .coef   (s1_data_r),
        .recip  (s1_recip_r),
        .result (rs_s)
    );

    // Stage 2: registered output beat, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= 6'd0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (!stall_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_data <= rs_s;
                out_idx  <= s1_idx_r;
                out_ch   <= s1_ch_r;
                out_last <= (s1_idx_r == 6'd63);
            end
        end
    end

    // Reciprocal tables: reloaded on reset, written only while fully idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int i = 0; i < BLK_BEATS; i++) begin
                    tbl_r[c][i] <= default_recip(c != 0, 6'(i));
                end
            end
        end else if (cfg_ok_s) begin
            tbl_r[cfg_ch][cfg_idx] <= cfg_recip;
        end
    end

    // One-cycle error pulse for every rejected config write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok_s;
        end
    end

endmodule

// File: tb/tb_quant_stream_multich.sv
// Directed bench for quant_stream_multich with hand-computed expectations.
module tb_quant_stream_multich;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_data;
    logic [1:0]  in_ch;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;
    logic [5:0]  out_idx;
    logic [1:0]  out_ch;
    logic        out_last;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [5:0]  cfg_idx;
    logic [12:0] cfg_recip;
    logic        cfg_err;
    logic        busy;

    quant_stream_multich dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_ch(out_ch), .out_last(out_last),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_idx(cfg_idx), .cfg_recip(cfg_recip),
        .cfg_err(cfg_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int total_got = 0;
    int acc_cyc = 0;

    logic [10:0] got_data [1024];
    logic [5:0]  got_idx  [1024];
    logic [1:0]  got_ch   [1024];
    logic        got_last [1024];
    int          got_cyc  [1024];

    // Cycle counter used to measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every output transfer, sampled mid-cycle.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got_data[total_got % 1024] <= out_data;
            got_idx[total_got % 1024]  <= out_idx;
            got_ch[total_got % 1024]   <= out_ch;
            got_last[total_got % 1024] <= out_last;
            got_cyc[total_got % 1024]  <= cyc;
            total_got <= total_got + 1;
        end
    end

    function automatic logic [31:0] sx(input logic [10:0] v);
        return {{21{v[10]}}, v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present beats first..last; optional channel change and output stall.
    task automatic send_beats(input logic [1:0] ch0, input int pat, input int first,
                              input int last, input int chg, input logic [1:0] ch_alt,
                              input int stall_b);
        int k;
        logic [10:0] snap_d;
        logic [5:0]  snap_i;
        for (int b = first; b <= last; b++) begin
            in_valid = 1'b1;
            in_data  = (pat == 1 && (b[3] ^ b[0])) ? 11'h400 : 11'd1023;
            in_ch    = (b < chg) ? ch0 : ch_alt;
            if (b == stall_b) begin
                out_ready = 1'b0;
                #1;
                chk("stall out_valid", 32'(out_valid), 32'd1);
                snap_d = out_data;
                snap_i = out_idx;
                for (int s = 0; s < 5; s++) begin
                    chk("stall in_ready", 32'(in_ready), 32'd0);
                    tick();
                    chk("stall hold idx", 32'(out_idx), 32'(snap_i));
                    chk("stall hold data", 32'(out_data), 32'(snap_d));
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
            k = 0;
            while (!in_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("accept bound", 32'(k < 50), 32'd1);
            if (b == 0) acc_cyc = cyc;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int target);
        int k;
        k = 0;
        while (total_got < target && k < 300) begin
            tick();
            k++;
        end
        chk("drain count", 32'(total_got), 32'(target));
        chk("idle busy", 32'(busy), 32'd0);
    endtask

    task automatic chk_block(input string tag, input int base, input logic [1:0] ch,
                             input int d0, input int d1, input int d63);
        for (int i = 0; i < 64; i++) begin
            chk({tag, " idx"}, 32'(got_idx[(base + i) % 1024]), 32'(i));
            chk({tag, " ch"}, 32'(got_ch[(base + i) % 1024]), 32'(ch));
            chk({tag, " last"}, 32'(got_last[(base + i) % 1024]), 32'(i == 63));
        end
        chk({tag, " d0"}, sx(got_data[base % 1024]), 32'(d0));
        chk({tag, " d1"}, sx(got_data[(base + 1) % 1024]), 32'(d1));
        chk({tag, " d63"}, sx(got_data[(base + 63) % 1024]), 32'(d63));
    endtask

    int base;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 11'd0; in_ch = 2'd0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_ch = 2'd0; cfg_idx = 6'd0; cfg_recip = 13'd0;
        repeat (3) tick();
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        chk("rst out_idx", 32'(out_idx), 32'd0);
        chk("rst out_ch", 32'(out_ch), 32'd0);
        chk("rst out_last", 32'(out_last), 32'd0);
        chk("rst cfg_err", 32'(cfg_err), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        @(negedge clk) rst = 1'b0;
        tick();

        // Luma defaults, all 1023.
        base = total_got;
        send_beats(2'd0, 0, 0, 63, 64, 2'd0, -1);
        wait_drain(base + 64);
        chk_block("luma", base, 2'd0, 64, 93, 10);

        // Chroma ch1 with 5-cycle output stall mid-block.
        base = total_got;
        send_beats(2'd1, 0, 0, 63, 64, 2'd1, 20);
        wait_drain(base + 64);
        chk_block("chroma bp", base, 2'd1, 60, 57, 10);

        // Checkerboard on ch2 and latency.
        base = total_got;
        send_beats(2'd2, 1, 0, 63, 64, 2'd2, -1);
        wait_drain(base + 64);
        chk_block("checker", base, 2'd2, 60, -57, 10);
        chk("latency", 32'(got_cyc[base % 1024] - acc_cyc), 32'd2);

        // Idle config writes: valid ch0 idx0, then out-of-range channel.
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_idx = 6'd0; cfg_recip = 13'd8191;
        tick();
        cfg_we = 1'b0;
        chk("cfg ok no err", 32'(cfg_err), 32'd0);
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_idx = 6'd5; cfg_recip = 13'd1;
        tick();
        cfg_we = 1'b0;
        chk("cfg bad ch err", 32'(cfg_err), 32'd1);
        tick();
        chk("cfg err pulse end", 32'(cfg_err), 32'd0);

        base = total_got;
        send_beats(2'd0, 0, 0, 63, 64, 2'd0, -1);
        wait_drain(base + 64);
        chk_block("luma sat", base, 2'd0, 1023, 93, 10);

        // Write with beat 0 and write mid-block are both rejected.
        in_valid = 1'b1; in_data = 11'd1023; in_ch = 2'd1;
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_idx = 6'd0; cfg_recip = 13'd1;
        base = total_got;
        tick();
        cfg_we = 1'b0; in_valid = 1'b0;
        chk("cfg beat0 rej", 32'(cfg_err), 32'd1);
        send_beats(2'd1, 0, 1, 9, 64, 2'd1, -1);
        chk("busy mid-block", 32'(busy), 32'd1);
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        chk("cfg busy rej", 32'(cfg_err), 32'd1);
        tick();
        chk("cfg busy pulse end", 32'(cfg_err), 32'd0);
        send_beats(2'd1, 0, 10, 63, 64, 2'd1, -1);
        wait_drain(base + 64);
        chk_block("cfg unchanged", base, 2'd1, 60, 57, 10);

        // in_ch=3 clamps to ch2; change at beat 10 ignored.
        base = total_got;
        send_beats(2'd3, 0, 0, 63, 10, 2'd0, -1);
        wait_drain(base + 64);
        chk_block("ch latch", base, 2'd2, 60, 57, 10);

        // Reset at beat 30 of a luma block.
        send_beats(2'd0, 0, 0, 29, 64, 2'd0, -1);
        rst = 1'b1;
        #1;
        chk("mid rst out_valid", 32'(out_valid), 32'd0);
        chk("mid rst out_data", 32'(out_data), 32'd0);
        chk("mid rst out_idx", 32'(out_idx), 32'd0);
        chk("mid rst out_last", 32'(out_last), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        @(negedge clk) rst = 1'b0;
        tick();
        base = total_got;
        send_beats(2'd0, 0, 0, 63, 64, 2'd0, -1);
        wait_drain(base + 64);
        chk_block("after rst", base, 2'd0, 64, 93, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
